// File: rtl/dma_io_responder.sv
// rtl/dma_io_responder.sv - 8237 DREQ/DACK peripheral responder with source/sink FIFOs (optional DMA_IO_ERRFLAG_EN)
module dma_io_responder #(
   parameter int DEPTH       = 8,
   parameter int DREQ_THRESH = 1,
   parameter bit DEMAND      = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       DIR,
   input  logic       DACK,
   input  logic       IOR,
   input  logic       IOW,
   inout  wire  [7:0] data,
   output logic       DREQ,
   output logic       READY_IO,
   input  logic [7:0] dev_wdata,
   input  logic       dev_wvalid,
   output logic       dev_wready,
   output logic [7:0] dev_rdata,
   output logic       dev_rvalid,
   input  logic       dev_rready
`ifdef DMA_IO_ERRFLAG_EN
   ,
   output logic       err_ovf,
   output logic       err_udf
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] THR  = CW'(DREQ_THRESH);

   logic [7:0]    src_mem_q [DEPTH];
   logic [7:0]    snk_mem_q [DEPTH];
   logic [PW-1:0] src_wp_q, src_rp_q, snk_wp_q, snk_rp_q;
   logic [CW-1:0] src_cnt_q, snk_cnt_q;
   logic          dreq_q, dreq_d;
   logic          hold_q, hold_d;
   logic          sup_q, sup_d;
   logic          done_q, stale_q, dir_q;

   logic strobe, illegal, xfer_r, xfer_w;
   logic src_push, src_pop, snk_push, snk_pop, fire;
   logic cond, exhausted;

   // A DIR flip while DACK is held is illegal: the latched direction only follows DIR while DACK is low.
   assign strobe   = DACK & (IOR | IOW);
   assign illegal  = DACK & (DIR != dir_q);
   assign xfer_r   = DACK & IOR & DIR & ~illegal;
   assign xfer_w   = DACK & IOW & ~DIR & ~illegal;

   // One transfer per strobe (done_q); a strobe that straddled reset is ignored (stale_q).
   assign READY_IO = ~done_q & ~stale_q &
                     ((xfer_r & (src_cnt_q != '0)) | (xfer_w & (snk_cnt_q != FULL)));
   assign src_pop  = xfer_r & READY_IO;
   assign snk_push = xfer_w & READY_IO;
   assign fire     = src_pop | snk_push;

   // A pop in the same cycle frees a slot, so a full source FIFO can still accept a push.
   assign dev_wready = (src_cnt_q != FULL) | src_pop;
   assign src_push   = dev_wvalid & dev_wready;
   assign dev_rvalid = (snk_cnt_q != '0);
   assign dev_rdata  = snk_mem_q[snk_rp_q];
   assign snk_pop    = dev_rready & dev_rvalid;

   assign data = xfer_r ? src_mem_q[src_rp_q] : 8'hzz;
   assign DREQ = dreq_q;

   assign cond      = DIR ? (src_cnt_q >= THR) : ((FULL - snk_cnt_q) >= THR);
   assign exhausted = DIR ? (src_cnt_q == '0) : (snk_cnt_q == FULL);

   // FIFO storage; contents need no reset since pointers and counts define validity.
   always_ff @(posedge clk) begin
      if (src_push) src_mem_q[src_wp_q] <= dev_wdata;
      if (snk_push) snk_mem_q[snk_wp_q] <= data;
   end

   // Pointers, counts, strobe bookkeeping and the DREQ register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         src_wp_q  <= '0;
         src_rp_q  <= '0;
         snk_wp_q  <= '0;
         snk_rp_q  <= '0;
         src_cnt_q <= '0;
         snk_cnt_q <= '0;
         dreq_q    <= 1'b0;
         hold_q    <= 1'b0;
         sup_q     <= 1'b0;
         done_q    <= 1'b0;
         stale_q   <= strobe;
         dir_q     <= DIR;
      end else begin
         if (src_push) src_wp_q <= src_wp_q + PW'(1);
         if (src_pop)  src_rp_q <= src_rp_q + PW'(1);
         if (snk_push) snk_wp_q <= snk_wp_q + PW'(1);
         if (snk_pop)  snk_rp_q <= snk_rp_q + PW'(1);
         src_cnt_q <= src_cnt_q + CW'(src_push) - CW'(src_pop);
         snk_cnt_q <= snk_cnt_q + CW'(snk_push) - CW'(snk_pop);
         dreq_q    <= dreq_d;
         hold_q    <= hold_d;
         sup_q     <= sup_d;
         if (!strobe)   done_q <= 1'b0;
         else if (fire) done_q <= 1'b1;
         if (!strobe)   stale_q <= 1'b0;
         if (!DACK)     dir_q <= DIR;
      end
   end

   // DREQ policy: single mode blanks after each transfer until DACK has been low a cycle;
   // demand mode holds until exhausted, then waits for the threshold to be crossed afresh.
   always_comb begin
      dreq_d = 1'b0;
      hold_d = hold_q;
      sup_d  = sup_q;
      if (DEMAND) begin
         if (dreq_q) begin
            dreq_d = ~exhausted;
            if (exhausted) hold_d = 1'b1;
         end else begin
            if (!cond) hold_d = 1'b0;
            dreq_d = cond & ~hold_q;
         end
      end else begin
         sup_d  = fire | (sup_q & DACK);
         dreq_d = cond & ~fire & ~sup_q;
      end
      if (illegal) dreq_d = 1'b0;
   end

`ifdef DMA_IO_ERRFLAG_EN
   logic [4:0] udf_cnt_q;
   logic       ovf_q, udf_q;

   // Sticky error flags: overflow attempts on either FIFO, and a read stalled beyond 16 cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         udf_cnt_q <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         if (xfer_r && (src_cnt_q == '0)) begin
            if (udf_cnt_q != 5'd16) udf_cnt_q <= udf_cnt_q + 5'd1;
            else                    udf_q     <= 1'b1;
         end else begin
            udf_cnt_q <= '0;
         end
         if ((dev_wvalid & ~dev_wready) | (xfer_w & (snk_cnt_q == FULL))) ovf_q <= 1'b1;
      end
   end

   assign err_ovf = ovf_q;
   assign err_udf = udf_q;
`endif

endmodule

// File: tb/tb_dma_io_responder.sv
// tb/tb_dma_io_responder.sv - self-checking bench for dma_io_responder (single-mode and demand-mode instances)
module tb_dma_io_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // Instance A: DEPTH 8, THRESH 1, single mode
   logic       a_dir, a_dack, a_ior, a_iow, a_wvalid, a_rready, a_drv;
   logic [7:0] a_wdata, a_dout;
   wire  [7:0] a_data;
   logic       a_dreq, a_ready, a_wready, a_rvalid;
   logic [7:0] a_rdata;
   assign a_data = a_drv ? a_dout : 8'hzz;

   // Instance B: DEPTH 8, THRESH 4, demand mode
   logic       b_dir, b_dack, b_ior, b_iow, b_wvalid, b_rready, b_drv;
   logic [7:0] b_wdata, b_dout;
   wire  [7:0] b_data;
   logic       b_dreq, b_ready, b_wready, b_rvalid;
   logic [7:0] b_rdata;
   assign b_data = b_drv ? b_dout : 8'hzz;

`ifdef DMA_IO_ERRFLAG_EN
   logic a_eovf, a_eudf, b_eovf, b_eudf;
`endif

   dma_io_responder #(.DEPTH(8), .DREQ_THRESH(1), .DEMAND(1'b0)) u_a (
      .clk(clk), .reset(reset), .DIR(a_dir), .DACK(a_dack), .IOR(a_ior), .IOW(a_iow),
      .data(a_data), .DREQ(a_dreq), .READY_IO(a_ready),
      .dev_wdata(a_wdata), .dev_wvalid(a_wvalid), .dev_wready(a_wready),
      .dev_rdata(a_rdata), .dev_rvalid(a_rvalid), .dev_rready(a_rready)
`ifdef DMA_IO_ERRFLAG_EN
      , .err_ovf(a_eovf), .err_udf(a_eudf)
`endif
   );

   dma_io_responder #(.DEPTH(8), .DREQ_THRESH(4), .DEMAND(1'b1)) u_b (
      .clk(clk), .reset(reset), .DIR(b_dir), .DACK(b_dack), .IOR(b_ior), .IOW(b_iow),
      .data(b_data), .DREQ(b_dreq), .READY_IO(b_ready),
      .dev_wdata(b_wdata), .dev_wvalid(b_wvalid), .dev_wready(b_wready),
      .dev_rdata(b_rdata), .dev_rvalid(b_rvalid), .dev_rready(b_rready)
`ifdef DMA_IO_ERRFLAG_EN
      , .err_ovf(b_eovf), .err_udf(b_eudf)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic read_one(input string nm, input logic [7:0] exp_d);
      a_dack = 1'b1; a_ior = 1'b1;
      @(negedge clk);
      chk({nm, "_ready"}, int'(a_ready), 1);
      chk({nm, "_data"}, int'(a_data), int'(exp_d));
      next_cycle();
      @(negedge clk);
      chk({nm, "_once"}, int'(a_ready), 0);
      next_cycle();
      a_dack = 1'b0; a_ior = 1'b0;
      next_cycle();
   endtask

   typedef struct {
      logic       dack;
      logic       ior;
      logic       wvalid;
      logic [7:0] wdata;
      logic       e_ready;
      logic       e_dreq;
      logic       e_wready;
      logic [7:0] e_data;
   } vec_t;

   vec_t tbl [15];

   // reference model state for the randomized phase
   logic [7:0] s_q[$];
   logic [7:0] k_q[$];

   initial begin
      bit   ok;
      bit   served, lowseen, exp_dreq, exp_dreq_n;
      bit   on, e_rdy, rd_pop, wr_push, e_wr, e_rv, cnd;
      int   plen;
      bit   gap;

      tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};

      reset = 1'b0;
      a_dir = 1'b1; a_dack = 1'b0; a_ior = 1'b0; a_iow = 1'b0; a_wvalid = 1'b0;
      a_rready = 1'b0; a_drv = 1'b0; a_wdata = 8'h00; a_dout = 8'h00;
      b_dir = 1'b0; b_dack = 1'b0; b_ior = 1'b0; b_iow = 1'b0; b_wvalid = 1'b0;
      b_rready = 1'b0; b_drv = 1'b0; b_wdata = 8'h00; b_dout = 8'h00;

      // reset then idle; the bus must be free for another driver
      repeat (2) @(posedge clk);
      #1;
      a_drv = 1'b1; a_dout = 8'h5A;
      @(negedge clk);
      chk("rst_a_dreq", int'(a_dreq), 0);
      chk("rst_a_ready", int'(a_ready), 0);
      chk("rst_a_wready", int'(a_wready), 1);
      chk("rst_a_rvalid", int'(a_rvalid), 0);
      chk("rst_a_bus_free", int'(a_data), 8'h5A);
      chk("rst_b_dreq", int'(b_dreq), 0);
      chk("rst_b_wready", int'(b_wready), 1);
      chk("rst_b_rvalid", int'(b_rvalid), 0);
      next_cycle();
      a_drv = 1'b0;
      reset = 1'b1;

      // source single mode, table driven
      for (int i = 0; i < 15; i++) begin
         a_dack = tbl[i].dack; a_ior = tbl[i].ior;
         a_wvalid = tbl[i].wvalid; a_wdata = tbl[i].wdata;
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), int'(a_ready), int'(tbl[i].e_ready));
         chk($sformatf("tbl%0d_dreq", i), int'(a_dreq), int'(tbl[i].e_dreq));
         chk($sformatf("tbl%0d_wready", i), int'(a_wready), int'(tbl[i].e_wready));
         if (tbl[i].e_ready)
            chk($sformatf("tbl%0d_data", i), int'(a_data), int'(tbl[i].e_data));
         next_cycle();
      end
      a_dack = 1'b0; a_ior = 1'b0; a_wvalid = 1'b0;

      // wait states on an empty source FIFO, released by a device push
      a_dack = 1'b1; a_ior = 1'b1;
      @(negedge clk); chk("ws_empty0", int'(a_ready), 0);
      next_cycle();
      @(negedge clk); chk("ws_empty1", int'(a_ready), 0);
      next_cycle();
      a_wvalid = 1'b1; a_wdata = 8'h77;
      @(negedge clk); chk("ws_pushcyc", int'(a_ready), 0);
      next_cycle();
      a_wvalid = 1'b0;
      @(negedge clk);
      chk("ws_ready", int'(a_ready), 1);
      chk("ws_data", int'(a_data), 8'h77);
      next_cycle();
      @(negedge clk); chk("ws_once", int'(a_ready), 0);
      next_cycle();
      a_dack = 1'b0; a_ior = 1'b0;
      next_cycle();

      // sink demand mode on B
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (b_dreq) ok = 1'b1;
      end
      chk("b_dreq_rise", int'(ok), 1);
      next_cycle();
      for (int i = 1; i <= 8; i++) begin
         b_dack = 1'b1; b_iow = 1'b1; b_drv = 1'b1; b_dout = 8'(i);
         @(negedge clk);
         chk($sformatf("b_wr%0d_ready", i), int'(b_ready), 1);
         chk($sformatf("b_wr%0d_dreq", i), int'(b_dreq), 1);
         next_cycle();
         @(negedge clk);
         chk($sformatf("b_wr%0d_once", i), int'(b_ready), 0);
         next_cycle();
         b_dack = 1'b0; b_iow = 1'b0; b_drv = 1'b0;
         next_cycle();
      end
      @(negedge clk);
      chk("b_full_dreq", int'(b_dreq), 0);
      next_cycle();
      b_dack = 1'b1; b_iow = 1'b1; b_drv = 1'b1; b_dout = 8'hEE;
      @(negedge clk);
      chk("b_full_wait", int'(b_ready), 0);
      next_cycle();
      b_dack = 1'b0; b_iow = 1'b0; b_drv = 1'b0;
      next_cycle();
      for (int i = 1; i <= 8; i++) begin
         b_rready = 1'b1;
         @(negedge clk);
         chk($sformatf("b_rd%0d_valid", i), int'(b_rvalid), 1);
         chk($sformatf("b_rd%0d_data", i), int'(b_rdata), i);
         next_cycle();
         b_rready = 1'b0;
         next_cycle();
         @(negedge clk);
         chk($sformatf("b_rd%0d_dreq", i), int'(b_dreq), (i >= 4) ? 1 : 0);
         next_cycle();
      end

      // full source FIFO: push and pop in the same cycle keep it full
      for (int i = 0; i < 8; i++) begin
         a_wvalid = 1'b1; a_wdata = 8'(8'h10 + i);
         @(negedge clk);
         chk($sformatf("fill%0d_wready", i), int'(a_wready), 1);
         next_cycle();
      end
      a_wdata = 8'h99;
      @(negedge clk);
      chk("full_wready", int'(a_wready), 0);
      next_cycle();
      a_dack = 1'b1; a_ior = 1'b1;
      @(negedge clk);
      chk("full_pp_ready", int'(a_ready), 1);
      chk("full_pp_data", int'(a_data), 8'h10);
      chk("full_pp_wready", int'(a_wready), 1);
      next_cycle();
      a_dack = 1'b0; a_ior = 1'b0; a_wvalid = 1'b0;
      @(negedge clk);
      chk("full_after_wready", int'(a_wready), 0);
      next_cycle();
      for (int i = 1; i < 8; i++) read_one($sformatf("drain%0d", i), 8'(8'h10 + i));
      read_one("drain8", 8'h99);

      // randomized run against the queue model, reset first so the model starts empty
      reset = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b1;
      s_q.delete(); k_q.delete();
      served = 1'b0; lowseen = 1'b1; exp_dreq = 1'b0;
      for (int ph = 0; ph < 2; ph++) begin
         a_dir = (ph == 0);
         plen = 0; gap = 1'b1;
         for (int c = 0; c < 600; c++) begin
            if (plen > 0) begin
               plen--;
               if (plen == 0) begin
                  a_dack = 1'b0; a_ior = 1'b0; a_iow = 1'b0; a_drv = 1'b0; gap = 1'b1;
               end
            end else if (!gap && ($urandom_range(0, 2) == 0)) begin
               plen = $urandom_range(1, 4);
               a_dack = 1'b1;
               if ($urandom_range(0, 9) == 0) begin
                  a_ior = ~a_dir; a_iow = a_dir;
               end else begin
                  a_ior = a_dir; a_iow = ~a_dir;
               end
               a_drv = a_iow; a_dout = 8'($urandom);
            end else begin
               gap = 1'b0;
            end
            a_wvalid = 1'($urandom); a_wdata = 8'($urandom); a_rready = 1'($urandom);

            @(negedge clk);
            on      = a_dack && (a_dir ? a_ior : a_iow);
            e_rdy   = on && !served && (a_dir ? (s_q.size() != 0) : (k_q.size() != 8));
            rd_pop  = e_rdy && a_dir;
            wr_push = e_rdy && !a_dir;
            e_wr    = (s_q.size() != 8) || rd_pop;
            e_rv    = (k_q.size() != 0);
            chk("rnd_ready", int'(a_ready), int'(e_rdy));
            if (rd_pop) chk("rnd_data", int'(a_data), int'(s_q[0]));
            chk("rnd_wready", int'(a_wready), int'(e_wr));
            chk("rnd_rvalid", int'(a_rvalid), int'(e_rv));
            if (e_rv) chk("rnd_rdata", int'(a_rdata), int'(k_q[0]));
            chk("rnd_dreq", int'(a_dreq), int'(exp_dreq));

            cnd = a_dir ? (s_q.size() >= 1) : ((8 - k_q.size()) >= 1);
            exp_dreq_n = cnd && !e_rdy && lowseen;
            if (e_rdy)        lowseen = 1'b0;
            else if (!a_dack) lowseen = 1'b1;
            served = on && (served || e_rdy);
            if (rd_pop) void'(s_q.pop_front());
            if (a_rready && e_rv) void'(k_q.pop_front());
            if (a_wvalid && e_wr) s_q.push_back(a_wdata);
            if (wr_push) k_q.push_back(a_dout);
            next_cycle();
            exp_dreq = exp_dreq_n;
         end
         a_dack = 1'b0; a_ior = 1'b0; a_iow = 1'b0; a_drv = 1'b0;
      end
      a_wvalid = 1'b0; a_rready = 1'b0;
      next_cycle();

      // reset in the middle of a strobe: the held strobe must stay ignored
      a_dir = 1'b1; a_wvalid = 1'b1; a_wdata = 8'h42;
      next_cycle();
      a_wvalid = 1'b0; a_dack = 1'b1; a_ior = 1'b1;
      next_cycle();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("mrst_ready", int'(a_ready), 0);
      chk("mrst_dreq", int'(a_dreq), 0);
      chk("mrst_wready", int'(a_wready), 1);
      chk("mrst_rvalid", int'(a_rvalid), 0);
      next_cycle();
      a_wvalid = 1'b1; a_wdata = 8'h5E;
      @(negedge clk);
      chk("mrst_hold0", int'(a_ready), 0);
      next_cycle();
      a_wvalid = 1'b0;
      @(negedge clk);
      chk("mrst_hold1", int'(a_ready), 0);
      next_cycle();
      a_dack = 1'b0; a_ior = 1'b0;
      @(negedge clk);
      chk("mrst_drop", int'(a_ready), 0);
      next_cycle();
      read_one("mrst_new", 8'h5E);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
